// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: shared constants and types for the divide/remainder controller.
//   - opcode encodings for the eight divide/remainder instructions
//   - reset-active level, zero word, FSM state encoding, run-watchdog limit
//   - prep_t: prepared operands plus bypass-detection flags
package div_ctrl_pkg;

  localparam logic        RSTENA   = 1'b1;
  localparam logic [63:0] ZEROWORD = 64'd0;

  localparam logic [7:0] INST_DIV   = 8'h30;
  localparam logic [7:0] INST_DIVU  = 8'h31;
  localparam logic [7:0] INST_DIVW  = 8'h32;
  localparam logic [7:0] INST_DIVUW = 8'h33;
  localparam logic [7:0] INST_REM   = 8'h34;
  localparam logic [7:0] INST_REMU  = 8'h35;
  localparam logic [7:0] INST_REMW  = 8'h36;
  localparam logic [7:0] INST_REMUW = 8'h37;

  // RUN cycles allowed before the watchdog forces a timed-out response
  localparam logic [7:0] RUN_TIMEOUT = 8'd80;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  typedef struct packed {
    logic [63:0] dividend;  // width-corrected dividend
    logic [63:0] divisor;   // width-corrected divisor
    logic        is_w;      // 32-bit (W) variant
    logic        is_rem;    // remainder rather than quotient
    logic        div_zero;  // prepared divisor is zero
    logic        ovf;       // signed most-negative / -1
  } prep_t;

  function automatic logic [63:0] sext32(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

endpackage

// File: rtl/div_operand_prep.sv
// div_operand_prep: combinational operand preparation.
//   opcode      in  8   request opcode
//   src1, src2  in  64  raw dividend / divisor
//   prep        out     prepared operands (W ops take src[31:0], sign- or
//                       zero-extended by signedness) plus zero-divisor and
//                       signed-overflow flags evaluated at the op width
module div_operand_prep
  import div_ctrl_pkg::*;
(
  input  logic [7:0]  opcode,
  input  logic [63:0] src1,
  input  logic [63:0] src2,
  output prep_t       prep
);

  logic is_w;
  logic is_signed;

  always_comb begin
    is_w      = (opcode == INST_DIVW) || (opcode == INST_DIVUW) ||
                (opcode == INST_REMW) || (opcode == INST_REMUW);
    is_signed = (opcode == INST_DIV)  || (opcode == INST_DIVW)  ||
                (opcode == INST_REM)  || (opcode == INST_REMW);

    prep        = '0;
    prep.is_w   = is_w;
    prep.is_rem = (opcode == INST_REM)  || (opcode == INST_REMU) ||
                  (opcode == INST_REMW) || (opcode == INST_REMUW);

    if (is_w) begin
      prep.dividend = is_signed ? sext32(src1[31:0]) : {32'd0, src1[31:0]};
      prep.divisor  = is_signed ? sext32(src2[31:0]) : {32'd0, src2[31:0]};
    end else begin
      prep.dividend = src1;
      prep.divisor  = src2;
    end

    prep.div_zero = (prep.divisor == ZEROWORD);
    // after sign extension a W divisor of -1 is all ones at 64 bits too
    prep.ovf = is_signed && (prep.divisor == {64{1'b1}}) &&
               (prep.dividend == (is_w ? 64'hFFFF_FFFF_8000_0000
                                       : 64'h8000_0000_0000_0000));
  end

endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: request/response controller wrapped around an iterative divider.
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           request handshake (ready only in IDLE)
//   req_opcode, req_src1/2        opcode, dividend, divisor
//   flush                         pipeline kill: aborts RUN/DONE, blocks accept
//   resp_valid/resp_ready         response handshake (valid in DONE)
//   resp_data, resp_timeout       width-corrected result, watchdog flag
//   busy                          state != IDLE
//   div_ready, div_dividend,      drive the divider; zero outside RUN
//   div_divisor, div_opcode
//   div_rem_data, div_finish      divider result and completion strobe
// Build option: DIV_CTRL_FASTPATH_EN resolves divide-by-zero and signed
// overflow without the divider (IDLE -> DONE in one cycle).
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_opcode,
  input  logic [63:0] req_src1,
  input  logic [63:0] req_src2,
  input  logic        flush,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_data,
  output logic        resp_timeout,
  output logic        busy,
  output logic        div_ready,
  output logic [63:0] div_dividend,
  output logic [63:0] div_divisor,
  output logic [7:0]  div_opcode,
  input  logic [63:0] div_rem_data,
  input  logic        div_finish
);

`ifdef DIV_CTRL_FASTPATH_EN
  localparam logic FAST_EN = 1'b1;
`else
  localparam logic FAST_EN = 1'b0;
`endif

  state_t      state;
  logic [7:0]  op_q;
  logic [63:0] dvd_q;
  logic [63:0] dvs_q;
  logic        w_q;
  logic [63:0] result_q;
  logic        timeout_q;
  logic [7:0]  run_cnt;

  prep_t       prep;
  logic        fast_hit;
  logic [63:0] fast_data;

  div_operand_prep u_prep (
    .opcode (req_opcode),
    .src1   (req_src1),
    .src2   (req_src2),
    .prep   (prep)
  );

  // Architectural results for the cases the divider is not trusted with.
  always_comb begin
    fast_hit  = FAST_EN && (prep.div_zero || prep.ovf);
    fast_data = {64{1'b1}};
    if (prep.div_zero) begin
      if (prep.is_rem)
        fast_data = prep.is_w ? sext32(prep.dividend[31:0]) : prep.dividend;
    end else if (prep.is_rem) begin
      fast_data = ZEROWORD;
    end else begin
      fast_data = prep.dividend;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RSTENA) begin
      state     <= ST_IDLE;
      op_q      <= '0;
      dvd_q     <= ZEROWORD;
      dvs_q     <= ZEROWORD;
      w_q       <= 1'b0;
      result_q  <= ZEROWORD;
      timeout_q <= 1'b0;
      run_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && !flush) begin
            op_q  <= req_opcode;
            dvd_q <= prep.dividend;
            dvs_q <= prep.divisor;
            w_q   <= prep.is_w;
            if (fast_hit) begin
              result_q  <= fast_data;
              timeout_q <= 1'b0;
              state     <= ST_DONE;
            end else begin
              run_cnt <= '0;
              state   <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          run_cnt <= run_cnt + 8'd1;
          if (flush) begin
            result_q  <= ZEROWORD;
            timeout_q <= 1'b0;
            state     <= ST_IDLE;
          end else if (div_finish) begin
            result_q  <= w_q ? sext32(div_rem_data[31:0]) : div_rem_data;
            timeout_q <= 1'b0;
            state     <= ST_DONE;
          end else if (run_cnt == RUN_TIMEOUT - 8'd1) begin
            // this is the last allowed RUN cycle; counter lands on the limit
            result_q  <= ZEROWORD;
            timeout_q <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (flush || resp_ready) begin
            result_q  <= ZEROWORD;
            timeout_q <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready    = (state == ST_IDLE);
  assign resp_valid   = (state == ST_DONE);
  assign busy         = (state != ST_IDLE);
  assign resp_data    = result_q;
  assign resp_timeout = timeout_q;

  assign div_ready    = (state == ST_RUN);
  assign div_dividend = div_ready ? dvd_q : ZEROWORD;
  assign div_divisor  = div_ready ? dvs_q : ZEROWORD;
  assign div_opcode   = div_ready ? op_q  : 8'd0;

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: self-checking bench for div_ctrl. A behavioural divider model
// answers div_ready after a programmable number of RUN cycles; expected
// results come from RISC-V divide semantics computed with plain arithmetic.
module tb_div_ctrl;
  import div_ctrl_pkg::*;

`ifdef DIV_CTRL_FASTPATH_EN
  localparam bit FAST_EN = 1'b1;
`else
  localparam bit FAST_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_opcode = 8'd0;
  logic [63:0] req_src1 = 64'd0;
  logic [63:0] req_src2 = 64'd0;
  logic        flush = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_data;
  logic        resp_timeout;
  logic        busy;
  logic        div_ready;
  logic [63:0] div_dividend;
  logic [63:0] div_divisor;
  logic [7:0]  div_opcode;
  logic [63:0] div_rem_data = 64'd0;
  logic        div_finish = 1'b0;

  int checks = 0;
  int fails  = 0;

  div_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_src1(req_src1), .req_src2(req_src2),
    .flush(flush), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_timeout(resp_timeout), .busy(busy),
    .div_ready(div_ready), .div_dividend(div_dividend),
    .div_divisor(div_divisor), .div_opcode(div_opcode),
    .div_rem_data(div_rem_data), .div_finish(div_finish)
  );

  always #5 clk = ~clk;

  // ---------------- reference semantics ----------------
  function automatic bit is_wop(input logic [7:0] op);
    return op == INST_DIVW || op == INST_DIVUW || op == INST_REMW || op == INST_REMUW;
  endfunction

  function automatic bit is_sop(input logic [7:0] op);
    return op == INST_DIV || op == INST_DIVW || op == INST_REM || op == INST_REMW;
  endfunction

  function automatic logic [63:0] sx(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

  function automatic logic [63:0] ref_res(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b);
    logic signed [63:0] sa, sb, sq;
    logic signed [31:0] sa32, sb32, sq32;
    logic [31:0] ua, ub;
    sa = a; sb = b; ua = a[31:0]; ub = b[31:0]; sa32 = ua; sb32 = ub;
    case (op)
      INST_DIV:  if (b == 0) return '1;
                 else if (a == 64'h8000_0000_0000_0000 && b == '1) return a;
                 else begin sq = sa / sb; return sq; end
      INST_DIVU: if (b == 0) return '1; else return a / b;
      INST_REM:  if (b == 0) return a;
                 else if (a == 64'h8000_0000_0000_0000 && b == '1) return 64'd0;
                 else begin sq = sa % sb; return sq; end
      INST_REMU: if (b == 0) return a; else return a % b;
      INST_DIVW: if (ub == 0) return '1;
                 else if (ua == 32'h8000_0000 && ub == '1) return sx(ua);
                 else begin sq32 = sa32 / sb32; return sx(sq32); end
      INST_DIVUW: if (ub == 0) return '1; else return sx(ua / ub);
      INST_REMW: if (ub == 0) return sx(ua);
                 else if (ua == 32'h8000_0000 && ub == '1) return 64'd0;
                 else begin sq32 = sa32 % sb32; return sx(sq32); end
      INST_REMUW: if (ub == 0) return sx(ua); else return sx(ua % ub);
      default: return 64'd0;
    endcase
  endfunction

  function automatic bit is_fast(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b);
    if (is_wop(op))
      return b[31:0] == 0 || (is_sop(op) && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
    return b == 0 || (is_sop(op) && a == 64'h8000_0000_0000_0000 && b == '1);
  endfunction

  function automatic logic [63:0] prep_ref(input logic [7:0] op, input logic [63:0] x);
    if (!is_wop(op)) return x;
    if (is_sop(op)) return sx(x[31:0]);
    return {32'd0, x[31:0]};
  endfunction

  // ---------------- divider model ----------------
  int model_lat = 5;
  bit model_hang = 1'b0;
  bit inject_finish = 1'b0;
  int run_seen = 0;

  always @(negedge clk) begin
    logic [63:0] r;
    div_finish = inject_finish;
    if (div_ready === 1'b1) begin
      run_seen++;
      if (!model_hang && run_seen == model_lat) begin
        r = ref_res(div_opcode, div_dividend, div_divisor);
        // W results only define the low word; scramble the rest
        if (is_wop(div_opcode)) r = {$urandom(), r[31:0]};
        div_rem_data = r;
        div_finish = 1'b1;
      end
    end else begin
      run_seen = 0;
    end
  end

  // ---------------- drivers (no checking) ----------------
  task automatic xact(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b,
                      input int lat, output int cycles, output int runs,
                      output logic [63:0] data, output logic to,
                      output logic [63:0] fdvd, output logic [63:0] fdvs, output bit got);
    model_lat = lat;
    @(negedge clk);
    req_opcode = op; req_src1 = a; req_src2 = b; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    cycles = 0; runs = 0; got = 0; data = 0; to = 0; fdvd = 0; fdvs = 0;
    for (int i = 0; i < 300; i++) begin
      if (resp_valid === 1'b1) begin
        got = 1; data = resp_data; to = resp_timeout;
        break;
      end
      if (div_ready === 1'b1) begin
        if (runs == 0) begin fdvd = div_dividend; fdvs = div_divisor; end
        runs++;
      end
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic ack();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (div_ready !== 1'b0) begin fails++; $display("FAIL reset_div_ready got=%b exp=0", div_ready); end
    checks++; if (resp_timeout !== 1'b0) begin fails++; $display("FAIL reset_timeout got=%b exp=0", resp_timeout); end
    checks++; if (resp_data !== 64'd0) begin fails++; $display("FAIL reset_resp_data got=%h exp=0", resp_data); end
    checks++; if (div_dividend !== 64'd0) begin fails++; $display("FAIL reset_div_dividend got=%h exp=0", div_dividend); end
  endtask

  task automatic test_div_basic();
    int cyc, runs; logic [63:0] d, fa, fb; logic to; bit got;
    xact(INST_DIV, 64'd100, 64'd7, 65, cyc, runs, d, to, fa, fb, got);
    checks++; if (!got) begin fails++; $display("FAIL basic_got_resp got=0 exp=1"); end
    checks++; if (runs != 65) begin fails++; $display("FAIL basic_run_cycles got=%0d exp=65", runs); end
    checks++; if (cyc != 65) begin fails++; $display("FAIL basic_latency got=%0d exp=65", cyc); end
    checks++; if (d !== 64'd14) begin fails++; $display("FAIL basic_data got=%h exp=14", d); end
    checks++; if (to !== 1'b0) begin fails++; $display("FAIL basic_timeout got=%b exp=0", to); end
    checks++; if (fa !== 64'd100 || fb !== 64'd7) begin fails++; $display("FAIL basic_div_operands got=%h/%h exp=100/7", fa, fb); end
    ack();
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_idle_after_ack busy=%b exp=0", busy); end
  endtask

  task automatic test_fastpath();
    int cyc, runs; logic [63:0] d, fa, fb; logic to; bit got;
    int exp_runs;
    exp_runs = FAST_EN ? 0 : 6;
    xact(INST_DIVW, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 6, cyc, runs, d, to, fa, fb, got);
    checks++; if (d !== 64'hFFFF_FFFF_8000_0000) begin fails++; $display("FAIL divw_ovf_data got=%h exp=ffffffff80000000", d); end
    checks++; if (runs != exp_runs || cyc != exp_runs) begin fails++; $display("FAIL divw_ovf_path runs=%0d cyc=%0d exp=%0d", runs, cyc, exp_runs); end
    ack();
    exp_runs = FAST_EN ? 0 : 4;
    xact(INST_REMU, 64'h1234, 64'd0, 4, cyc, runs, d, to, fa, fb, got);
    checks++; if (d !== 64'h1234) begin fails++; $display("FAIL remu_zero_data got=%h exp=1234", d); end
    checks++; if (runs != exp_runs || cyc != exp_runs) begin fails++; $display("FAIL remu_zero_path runs=%0d cyc=%0d exp=%0d", runs, cyc, exp_runs); end
    ack();
  endtask

  task automatic test_flush();
    bit bad; int cyc, runs; logic [63:0] d, fa, fb; logic to; bit got;
    model_hang = 1'b1;
    @(negedge clk);
    req_opcode = INST_DIV; req_src1 = 64'd50; req_src2 = 64'd5; req_valid = 1'b1;
    @(negedge clk);                    // RUN cycle 1
    req_valid = 1'b0;
    repeat (9) @(negedge clk);         // RUN cycle 10
    checks++; if (div_ready !== 1'b1) begin fails++; $display("FAIL flush_pre_run div_ready=%b exp=1", div_ready); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (busy !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL flush_to_idle busy=%b req_ready=%b exp=0/1", busy, req_ready); end
    checks++; if (div_ready !== 1'b0 || div_dividend !== 64'd0) begin fails++; $display("FAIL flush_div_ready got=%b/%h exp=0/0", div_ready, div_dividend); end
    model_hang = 1'b0;
    inject_finish = 1'b1;
    bad = 0;
    repeat (2) begin @(negedge clk); if (resp_valid !== 1'b0 || busy !== 1'b0) bad = 1; end
    inject_finish = 1'b0;
    repeat (3) begin @(negedge clk); if (resp_valid !== 1'b0 || busy !== 1'b0) bad = 1; end
    checks++; if (bad) begin fails++; $display("FAIL flush_late_finish resp_valid/busy rose, exp 0"); end
    // flush in IDLE blocks acceptance
    req_opcode = INST_DIVU; req_src1 = 64'd9; req_src2 = 64'd3; req_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL flush_idle_block busy=%b exp=0", busy); end
    xact(INST_DIVU, 64'd1000, 64'd10, 3, cyc, runs, d, to, fa, fb, got);
    checks++; if (!got || d !== 64'd100 || cyc != 3) begin fails++; $display("FAIL flush_next_req got=%0d data=%h cyc=%0d exp=1/64/3", got, d, cyc); end
    ack();
  endtask

  task automatic test_timeout();
    int cyc, runs; logic [63:0] d, fa, fb; logic to; bit got;
    model_hang = 1'b1;
    xact(INST_DIV, 64'd123, 64'd4, 1, cyc, runs, d, to, fa, fb, got);
    model_hang = 1'b0;
    checks++; if (!got || runs != 80 || cyc != 80) begin fails++; $display("FAIL timeout_len got=%0d runs=%0d cyc=%0d exp=1/80/80", got, runs, cyc); end
    checks++; if (to !== 1'b1) begin fails++; $display("FAIL timeout_flag got=%b exp=1", to); end
    checks++; if (d !== 64'd0) begin fails++; $display("FAIL timeout_data got=%h exp=0", d); end
    ack();
  endtask

  task automatic test_backpressure();
    int cyc, runs; logic [63:0] d, fa, fb, exp; logic to; bit got, bad;
    exp = ref_res(INST_REM, -64'sd17, 64'd5);
    xact(INST_REM, -64'sd17, 64'd5, 4, cyc, runs, d, to, fa, fb, got);
    checks++; if (!got || d !== exp) begin fails++; $display("FAIL bp_data got=%h exp=%h", d, exp); end
    req_opcode = INST_DIVU; req_src1 = 64'd8; req_src2 = 64'd2; req_valid = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_data !== exp || req_ready !== 1'b0) bad = 1;
    end
    checks++; if (bad) begin fails++; $display("FAIL bp_hold resp not stable or req_ready high, exp data=%h", exp); end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0; req_valid = 1'b0;
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL bp_release valid=%b ready=%b busy=%b exp=0/1/0", resp_valid, req_ready, busy); end
  endtask

  task automatic test_reset_mid_run();
    model_hang = 1'b1;
    @(negedge clk);
    req_opcode = INST_DIV; req_src1 = 64'd77; req_src2 = 64'd7; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1; flush = 1'b1; inject_finish = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || resp_valid !== 1'b0 || div_ready !== 1'b0 || req_ready !== 1'b1 || resp_data !== 64'd0)
      begin fails++; $display("FAIL rst_mid_run busy=%b valid=%b div_ready=%b ready=%b data=%h exp=0/0/0/1/0", busy, resp_valid, div_ready, req_ready, resp_data); end
    rst = 1'b0; flush = 1'b0; inject_finish = 1'b0; model_hang = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [7:0] ops [8];
    int cyc, runs, lat, exp_cyc; logic [63:0] a, b, d, fa, fb, exp; logic [7:0] op; logic to; bit got, fast;
    ops = '{INST_DIV, INST_DIVU, INST_DIVW, INST_DIVUW, INST_REM, INST_REMU, INST_REMW, INST_REMUW};
    for (int n = 0; n < 24; n++) begin
      op = ops[$urandom_range(0, 7)];
      case ($urandom_range(0, 4))
        0: begin a = {$urandom(), $urandom()}; b = is_wop(op) ? {$urandom(), 32'd0} : 64'd0; end
        1: begin
             a = is_wop(op) ? {$urandom(), 32'h8000_0000} : 64'h8000_0000_0000_0000;
             b = is_wop(op) ? {$urandom(), 32'hFFFF_FFFF} : 64'hFFFF_FFFF_FFFF_FFFF;
           end
        2: begin
             a = 64'($urandom_range(0, 1000)); b = 64'($urandom_range(1, 20));
             if ($urandom_range(0, 1) == 1) a = -a;
             if ($urandom_range(0, 1) == 1) b = -b;
           end
        default: begin a = {$urandom(), $urandom()}; b = {$urandom(), $urandom()} >> $urandom_range(0, 60); end
      endcase
      lat = $urandom_range(1, 20);
      exp = ref_res(op, a, b);
      fast = FAST_EN && is_fast(op, a, b);
      exp_cyc = fast ? 0 : lat;
      xact(op, a, b, lat, cyc, runs, d, to, fa, fb, got);
      checks++; if (!got || d !== exp || to !== 1'b0) begin fails++; $display("FAIL rand_data op=%h a=%h b=%h got=%h exp=%h", op, a, b, d, exp); end
      checks++; if (cyc != exp_cyc) begin fails++; $display("FAIL rand_latency op=%h got=%0d exp=%0d", op, cyc, exp_cyc); end
      if (!fast) begin
        checks++; if (fa !== prep_ref(op, a) || fb !== prep_ref(op, b))
          begin fails++; $display("FAIL rand_prep op=%h got=%h/%h exp=%h/%h", op, fa, fb, prep_ref(op, a), prep_ref(op, b)); end
      end
      ack();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_div_basic();
    test_fastpath();
    test_flush();
    test_timeout();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
